// File: rtl/alu_vector_runner.sv
// Stimulus/response engine for the 6-bit ALU: drives a fixed
// 16-entry vector set, checks every response and keeps tallies.
module alu_vector_runner #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [5:0] A,
  output logic [5:0] B,
  output logic [2:0] mode,
  input  logic [5:0] out,
  input  logic       f_cout,
  input  logic       f_ovf,
  output logic       busy,
  output logic       done,
  output logic [3:0] cur_idx,
  output logic [4:0] pass_count,
  output logic [4:0] fail_count,
  output logic       fail_flag,
  output logic [3:0] first_fail
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

  state_t     r_state;
  logic [3:0] r_cnt;

  logic [6:0] w_sum;
  logic [5:0] w_res;
  logic       w_c;
  logic       w_v;
  logic       w_match;
  logic       w_last;
  logic [3:0] w_next;

  // {A, B} operand pair for each vector index
  function automatic logic [11:0] rom(input logic [3:0] i);
    logic [11:0] v;
    unique case (i)
      4'd0:  v = {6'h00, 6'h3F};
      4'd1:  v = {6'h01, 6'h20};
      4'd2:  v = {6'h03, 6'h30};
      4'd3:  v = {6'h07, 6'h38};
      4'd4:  v = {6'h0F, 6'h3C};
      4'd5:  v = {6'h1F, 6'h3E};
      4'd6:  v = {6'h1A, 6'h06};
      4'd7:  v = {6'h18, 6'h36};
      4'd8:  v = {6'h33, 6'h33};
      4'd9:  v = {6'h0C, 6'h0C};
      4'd10: v = {6'h02, 6'h03};
      4'd11: v = {6'h04, 6'h05};
      4'd12: v = {6'h04, 6'h31};
      4'd13: v = {6'h0E, 6'h33};
      4'd14: v = {6'h1D, 6'h2A};
      4'd15: v = {6'h33, 6'h0C};
    endcase
    return v;
  endfunction

  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    unique case (mode)
      3'd0: begin
        w_sum = {1'b0, A} + {1'b0, B};
        w_res = w_sum[5:0];
        w_c   = w_sum[6];
        w_v   = (A[5] == B[5]) && (w_sum[5] != A[5]);
      end
      3'd1: begin
        w_sum = {1'b0, A} + {1'b0, ~B} + 7'd1;
        w_res = w_sum[5:0];
        w_c   = w_sum[6];
        w_v   = (A[5] != B[5]) && (w_sum[5] != A[5]);
      end
      3'd2: w_res = A & B;
      3'd3: w_res = A | B;
      3'd4: w_res = A ^ B;
      3'd5: begin
        w_sum = {1'b0, A} + 7'd1;
        w_res = w_sum[5:0];
        w_c   = w_sum[6];
        w_v   = (A == 6'h1F);
      end
      3'd6: begin
        w_res = {A[4:0], 1'b0};
        w_c   = A[5];
      end
      3'd7: begin
        w_res = {1'b0, A[5:1]};
        w_c   = A[0];
      end
    endcase
  end

  assign w_match = ({f_cout, f_ovf, out} == {w_c, w_v, w_res});
  assign w_last  = (cur_idx == 4'd15) || (STOP_ON_FAIL && !w_match);
  assign w_next  = cur_idx + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      A          <= '0;
      B          <= '0;
      mode       <= '0;
      cur_idx    <= '0;
      pass_count <= '0;
      fail_count <= '0;
      first_fail <= '0;
      fail_flag  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            pass_count <= '0;
            fail_count <= '0;
            fail_flag  <= 1'b0;
            first_fail <= '0;
            cur_idx    <= '0;
            {A, B}     <= rom(4'd0);
            mode       <= '0;
            busy       <= 1'b1;
            r_state    <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          r_cnt   <= LP_SETTLE;
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_match) pass_count <= pass_count + 5'd1;
          else         fail_count <= fail_count + 5'd1;
          if (!w_match && !fail_flag) begin
            fail_flag  <= 1'b1;
            first_fail <= cur_idx;
          end
          // next vector is loaded on the edge that enters DRIVE
          if (w_last) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            cur_idx <= w_next;
            {A, B}  <= rom(w_next);
            mode    <= w_next[3:1];
            r_state <= S_DRIVE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_vector_runner.md
# alu_vector_runner

On-board stimulus/response engine for the 6-bit ALU (`main`) on the Basys3 board. After `start`, it drives a fixed 16-entry vector set into the ALU's `A`/`B`/`mode` inputs, one vector at a time. For each vector it waits a settle interval, then samples `out`/`f_cout`/`f_ovf` and compares them against an internal golden model. Pass/fail tallies and the first failing index are exposed for LEDs and seven-segment display.

## Interface
- `SETTLE_CYCLES`, default 2: clock cycles between driving a vector and sampling the response; legal range 1–15.
- `STOP_ON_FAIL`, default 0: 1 ends the run at the first mismatch.
- `clk`  in  1  system clock.
- `reset`  in  1  reset; synchronous, active-high.
- `start`  in  1  level; a run begins in any IDLE cycle where `start`=1.
- `A`  out  6  ALU operand A.
- `B`  out  6  ALU operand B.
- `mode`  out  3  ALU operation select.
- `out`  in  6  ALU result.
- `f_cout`  in  1  ALU carry flag.
- `f_ovf`  in  1  ALU overflow flag.
- `busy`  out  1  high from the first DRIVE cycle through the last CHECK cycle.
- `done`  out  1  one-cycle pulse at run end.
- `cur_idx`  out  4  index of the vector currently driven.
- `pass_count`  out  5  vectors matched this run (0–16).
- `fail_count`  out  5  vectors mismatched this run (0–16).
- `fail_flag`  out  1  sticky; set on any mismatch in this run.
- `first_fail`  out  4  index of the first mismatch; valid when `fail_flag`=1.

## Operation
- **Vector ROM**, index i = 0..15, `mode` = i[3:1]. A/B pairs in hex, in index order:
  - 00/3F, 01/20, 03/30, 07/38
  - 0F/3C, 1F/3E, 1A/06, 18/36
  - 33/33, 0C/0C, 02/03, 04/05
  - 04/31, 0E/33, 1D/2A, 33/0C
- **Golden model**. Compute in 7 bits; `cout` = bit 6 unless stated; `ovf` = 0 unless stated.
  - 000: A+B. `ovf` = signed overflow.
  - 001: A+~B+1. `cout`=1 means no borrow. `ovf` = signed overflow.
  - 010: A&B, `cout`=0.
  - 011: A|B, `cout`=0.
  - 100: A^B, `cout`=0.
  - 101: A+1. `cout` = carry out. `ovf` = 1 iff A=1F.
  - 110: A<<1. `cout` = A[5].
  - 111: A>>1 (logical). `cout` = A[0].
- **Match**: {`f_cout`, `f_ovf`, `out`} equals the expected 8-bit value exactly.
- **FSM**: IDLE → DRIVE → SETTLE → CHECK → (DRIVE with idx+1 | DONE) → IDLE.
  - IDLE: when `start`=1, clear counts, `fail_flag` and `first_fail`; idx ← 0; go to DRIVE.
  - DRIVE: register `A`/`B`/`mode` from ROM[idx]. Load the settle counter with `SETTLE_CYCLES`.
  - SETTLE: decrement the counter; leave when it reaches 0.
  - CHECK: sample the ALU outputs. Increment `pass_count` or `fail_count`. On the first fail, set `fail_flag` and `first_fail` ← idx. Next state:
    - DONE if idx=15, or if `STOP_ON_FAIL`=1 and this vector failed;
    - otherwise idx+1 and DRIVE.
  - DONE: assert `done` for one cycle, then go to IDLE.
- `start` is ignored outside IDLE. Holding `start` high re-runs continuously; DONE → IDLE → DRIVE adds 2 cycles between runs.
- Results (counts, `fail_flag`, `first_fail`) hold after the run until the next accepted `start`.
- `A`/`B`/`mode` hold their last vector in IDLE/DONE.

## Timing
- **Reset values**:
  - state IDLE;
  - `A`, `B`, `mode`, `cur_idx`, `pass_count`, `fail_count`, `first_fail` = 0;
  - `busy`, `done`, `fail_flag` = 0.
- **`reset` mid-run**: on the next edge, everything returns to reset values. A partial run leaves no state behind.
- `A`/`B`/`mode`/`cur_idx` are registered and change on the edge that enters DRIVE.
- **Per vector**: 1 DRIVE + `SETTLE_CYCLES` SETTLE + 1 CHECK = `SETTLE_CYCLES`+2 cycles. The ALU sees stable inputs for ≥ `SETTLE_CYCLES` full cycles before the sample.
- **Full run**: 16·(`SETTLE_CYCLES`+2) cycles from the first DRIVE to the last CHECK. `done` is asserted in the following cycle. Default: 64 cycles, `done` in cycle 65 after `start` is sampled.
- Counter updates become visible on the edge ending CHECK.
- Counters saturate at 16 and cannot wrap, since the maximum count is 16.

## Test plan
- **Correct ALU model, `SETTLE_CYCLES`=2.** Assert `start` for 1 cycle → vector 0 drives A=00, B=3F, mode=0, expected out=3F, cout=0, ovf=0. Vector 2 expects out=13, cout=0, ovf=0. At the end: `done` pulse exactly 65 cycles after `start`, `pass_count`=16, `fail_count`=0, `fail_flag`=0.
- **ALU with `f_cout` stuck-at-0.** → fails only vectors 14 and 15: `fail_count`=2, `pass_count`=14, `first_fail`=14, `fail_flag`=1.
- **Same fault with `STOP_ON_FAIL`=1.** → run ends after the CHECK of vector 14: `pass_count`=14, `fail_count`=1, `cur_idx`=14, `done` pulse.
- **`reset` asserted while `cur_idx`=7.** → next cycle all outputs at reset values, `busy`=0. A new `start` then gives the full 16-vector result.
- **`start` pulsed while `busy`.** → ignored; the run completes unchanged. Holding `start` high → a second run starts 2 cycles after `done` and its counts restart at 0.
- **`SETTLE_CYCLES`=1 with a correct ALU.** → `done` at cycle 49, 16 passes.
